// File: rtl/sock_mux_pkg.sv
// rtl/sock_mux_pkg.sv - shared types and link-word pack/unpack helpers for sock_chan_mux
package sock_mux_pkg;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  // Helpers work on a link word sized for the widest supported layout;
  // callers pass their real payload and channel-id widths.
  localparam int MAX_DW = 64;
  localparam int MAX_CW = 4;
  localparam int MAX_LW = MAX_DW + MAX_CW + 1;

  typedef logic [MAX_LW-1:0] link_t;

  function automatic int last_bit(input int dw, input int cw);
    return dw + cw;
  endfunction

  function automatic int ch_lsb(input int dw);
    return dw;
  endfunction

  function automatic link_t pack_link(input logic last, input logic [MAX_CW-1:0] ch,
                                      input logic [MAX_DW-1:0] data, input int dw, input int cw);
    link_t w;
    w = '0;
    for (int i = 0; i < MAX_DW; i++) if (i < dw) w[i] = data[i];
    for (int i = 0; i < MAX_CW; i++) if (i < cw) w[ch_lsb(dw) + i] = ch[i];
    w[last_bit(dw, cw)] = last;
    return w;
  endfunction

  function automatic logic [MAX_CW-1:0] unpack_ch(input link_t w, input int dw, input int cw);
    logic [MAX_CW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_CW; i++) if (i < cw) r[i] = w[ch_lsb(dw) + i];
    return r;
  endfunction

  function automatic logic unpack_last(input link_t w, input int dw, input int cw);
    return w[last_bit(dw, cw)];
  endfunction

  function automatic logic [MAX_DW-1:0] unpack_data(input link_t w, input int dw);
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DW; i++) if (i < dw) r[i] = w[i];
    return r;
  endfunction

endpackage

// File: rtl/sock_rx_fifo.sv
// rtl/sock_rx_fifo.sv - synchronous RX FIFO with occupancy count and sticky overflow flag
module sock_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_wr, do_rd;

  // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    do_rd   = rd_en & ~empty;
    do_wr   = wr_en & (~full | do_rd);
    rd_data = mem[rd_ptr];
  end

  // Pointer, occupancy and overflow bookkeeping; a rejected write sets ovf until rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
      if (wr_en & ~do_wr) ovf <= 1'b1;
    end
  end

  // Storage is not reset; clearing the pointers discards its contents.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/sock_chan_mux.sv
// rtl/sock_chan_mux.sv - round-robin packet mux/demux sharing one socket link between channels
module sock_chan_mux
  import sock_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 32,
  parameter int RX_DEPTH = 4,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int LW = DWIDTH + CH_W + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DWIDTH-1:0] s_tx_data,
  input  logic [NUM_CH-1:0]        s_tx_valid,
  input  logic [NUM_CH-1:0]        s_tx_last,
  output logic [NUM_CH-1:0]        s_tx_ready,
  output logic [LW-1:0]            socket_dout,
  output logic                     socket_dout_valid,
  input  logic [LW-1:0]            socket_din,
  input  logic                     socket_din_valid,
  output logic                     socket_din_ready,
  output logic [DWIDTH-1:0]        m_rx_data,
  output logic [NUM_CH-1:0]        m_rx_valid,
  output logic                     m_rx_last,
  input  logic [NUM_CH-1:0]        m_rx_ready,
  output logic                     err_bad_ch,
  output logic                     err_rx_ovf
);

  localparam int CNT_W = $clog2(RX_DEPTH + 1);

  state_t              state, state_nxt;
  logic [CH_W-1:0]     gnt, rr_ptr, pick_ch, cur_ch;
  logic                pick_found, accept, acc_last;
  logic [MAX_DW-1:0]   acc_data;

  logic [LW-1:0]       rx_head;
  logic                rx_empty, rx_pop;
  logic [CNT_W-1:0]    rx_count;
  link_t               head_w;
  logic [MAX_CW-1:0]   head_ch;
  logic                head_bad;

  // Round-robin scan starting at rr_ptr; the first valid channel wins.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!pick_found && s_tx_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
        pick_found = 1'b1;
        pick_ch    = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  // TX grant and next state: a burst locks the link to gnt until its last beat.
  always_comb begin
    state_nxt  = state;
    s_tx_ready = '0;
    cur_ch     = (state == BURST) ? gnt : pick_ch;
    if (!rst) begin
      if (state == BURST)  s_tx_ready[gnt] = 1'b1;
      else if (pick_found) s_tx_ready[pick_ch] = 1'b1;
    end
    accept   = s_tx_valid[cur_ch] & s_tx_ready[cur_ch];
    acc_last = s_tx_last[cur_ch];
    acc_data = '0;
    acc_data[DWIDTH-1:0] = s_tx_data[int'(cur_ch)*DWIDTH +: DWIDTH];
    if (accept) state_nxt = acc_last ? IDLE : BURST;
  end

  // TX state, pointer update and the registered link word toward the wrapper.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      gnt               <= '0;
      rr_ptr            <= '0;
      socket_dout       <= '0;
      socket_dout_valid <= 1'b0;
    end else begin
      state             <= state_nxt;
      socket_dout_valid <= accept;
      if (accept) begin
        socket_dout <= LW'(pack_link(acc_last, MAX_CW'(cur_ch), acc_data, DWIDTH, CH_W));
        if (acc_last) rr_ptr <= CH_W'((int'(cur_ch) + 1) % NUM_CH);
        else          gnt    <= cur_ch;
      end
    end
  end

  sock_rx_fifo #(.DEPTH(RX_DEPTH), .W(LW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (socket_din_valid),
    .wr_data (socket_din),
    .rd_en   (rx_pop),
    .rd_data (rx_head),
    .empty   (rx_empty),
    .count   (rx_count),
    .ovf     (err_rx_ovf)
  );

  // Route the FIFO head to its channel; unused channel codes are dropped at once.
  always_comb begin
    head_w = '0;
    head_w[LW-1:0] = rx_head;
    head_ch  = unpack_ch(head_w, DWIDTH, CH_W);
    head_bad = (int'(head_ch) >= NUM_CH);
    m_rx_valid = '0;
    rx_pop     = 1'b0;
    err_bad_ch = 1'b0;
    m_rx_data  = '0;
    m_rx_last  = 1'b0;
    socket_din_ready = !rst && (int'(rx_count) <= RX_DEPTH - 2);
    if (!rx_empty) begin
      m_rx_data = DWIDTH'(unpack_data(head_w, DWIDTH));
      m_rx_last = unpack_last(head_w, DWIDTH, CH_W);
      if (head_bad) begin
        rx_pop     = 1'b1;
        err_bad_ch = 1'b1;
      end else begin
        m_rx_valid[head_ch[CH_W-1:0]] = 1'b1;
        rx_pop = m_rx_ready[head_ch[CH_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_sock_chan_mux.sv
// tb/tb_sock_chan_mux.sv - self-checking bench for sock_chan_mux
module tb_sock_chan_mux;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int DEP = 4;
  localparam int LW  = 35;
  localparam int N3  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*DW-1:0] s_tx_data;
  logic [N-1:0]    s_tx_valid, s_tx_last, s_tx_ready;
  logic [LW-1:0]   socket_dout, socket_din;
  logic            socket_dout_valid, socket_din_valid, socket_din_ready;
  logic [DW-1:0]   m_rx_data;
  logic [N-1:0]    m_rx_valid, m_rx_ready;
  logic            m_rx_last, err_bad_ch, err_rx_ovf;

  logic [N3*DW-1:0] tx3_data;
  logic [N3-1:0]    tx3_valid, tx3_last, tx3_ready;
  logic [LW-1:0]    dout3, din3;
  logic             dout3_valid, din3_valid, din3_ready;
  logic [DW-1:0]    m_rx_data3;
  logic [N3-1:0]    m_rx_valid3, m_rx_ready3;
  logic             m_rx_last3, err_bad3, ovf3;

  int n_cmp = 0;
  int n_bad = 0;

  sock_chan_mux #(.NUM_CH(N), .DWIDTH(DW), .RX_DEPTH(DEP)) u_dut (
    .clk(clk), .rst(rst),
    .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_last(s_tx_last), .s_tx_ready(s_tx_ready),
    .socket_dout(socket_dout), .socket_dout_valid(socket_dout_valid),
    .socket_din(socket_din), .socket_din_valid(socket_din_valid), .socket_din_ready(socket_din_ready),
    .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_last(m_rx_last), .m_rx_ready(m_rx_ready),
    .err_bad_ch(err_bad_ch), .err_rx_ovf(err_rx_ovf)
  );

  sock_chan_mux #(.NUM_CH(N3), .DWIDTH(DW), .RX_DEPTH(DEP)) u_dut3 (
    .clk(clk), .rst(rst),
    .s_tx_data(tx3_data), .s_tx_valid(tx3_valid), .s_tx_last(tx3_last), .s_tx_ready(tx3_ready),
    .socket_dout(dout3), .socket_dout_valid(dout3_valid),
    .socket_din(din3), .socket_din_valid(din3_valid), .socket_din_ready(din3_ready),
    .m_rx_data(m_rx_data3), .m_rx_valid(m_rx_valid3), .m_rx_last(m_rx_last3), .m_rx_ready(m_rx_ready3),
    .err_bad_ch(err_bad3), .err_rx_ovf(ovf3)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    s_tx_data = '0; s_tx_valid = '0; s_tx_last = '0;
    socket_din = '0; socket_din_valid = 1'b0; m_rx_ready = '0;
    tx3_data = '0; tx3_valid = '0; tx3_last = '0;
    din3 = '0; din3_valid = 1'b0; m_rx_ready3 = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    s_tx_valid = 4'b1111;
    tick();
    tick();
    n_cmp++; if (s_tx_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_tx_ready got %b want 0000", s_tx_ready); end
    n_cmp++; if (socket_dout_valid !== 1'b0 || socket_dout !== '0) begin n_bad++; $display("FAIL rst_dout got %b/%h want 0/0", socket_dout_valid, socket_dout); end
    n_cmp++; if (socket_din_ready !== 1'b0) begin n_bad++; $display("FAIL rst_din_ready got %b want 0", socket_din_ready); end
    n_cmp++; if (m_rx_valid !== 4'b0000 || err_bad_ch !== 1'b0 || err_rx_ovf !== 1'b0) begin n_bad++; $display("FAIL rst_rx got v=%b bad=%b ovf=%b want 0", m_rx_valid, err_bad_ch, err_rx_ovf); end
    n_cmp++; if (tx3_ready !== 3'b000 || dout3 !== '0 || dout3_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dut3_tx got %b/%h want 0", tx3_ready, dout3); end
    rst = 1'b0;
    s_tx_valid = '0;
    #1;
    n_cmp++; if (socket_din_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_din_ready got %b want 1", socket_din_ready); end
  endtask

  task automatic test_burst3();
    logic [DW-1:0] d [3];
    logic [LW-1:0] exp_w;
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      s_tx_valid = 4'b0001;
      s_tx_data = '0;
      s_tx_data[DW-1:0] = d[i];
      s_tx_last = (i == 2) ? 4'b0001 : 4'b0000;
      #1;
      n_cmp++; if (s_tx_ready !== 4'b0001) begin n_bad++; $display("FAIL t1_ready beat%0d got %b want 0001", i, s_tx_ready); end
      tick();
      exp_w = {(i == 2), 2'd0, d[i]};
      n_cmp++; if (socket_dout_valid !== 1'b1 || socket_dout !== exp_w) begin n_bad++; $display("FAIL t1_dout beat%0d got %b/%h want 1/%h", i, socket_dout_valid, socket_dout, exp_w); end
    end
    s_tx_valid = '0;
    tick();
    n_cmp++; if (socket_dout_valid !== 1'b0) begin n_bad++; $display("FAIL t1_idle_valid got %b want 0", socket_dout_valid); end
  endtask

  task automatic test_round_robin();
    logic [LW-1:0] exp_w;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      s_tx_valid = 4'b1010;
      s_tx_last = 4'b1111;
      s_tx_data = '0;
      s_tx_data[1*DW +: DW] = 32'(32'h100 + rep);
      s_tx_data[3*DW +: DW] = 32'(32'h300 + rep);
      #1;
      n_cmp++; if (s_tx_ready !== 4'b0010) begin n_bad++; $display("FAIL t2_first_ready rep%0d got %b want 0010", rep, s_tx_ready); end
      tick();
      exp_w = {1'b1, 2'd1, 32'(32'h100 + rep)};
      n_cmp++; if (socket_dout_valid !== 1'b1 || socket_dout !== exp_w) begin n_bad++; $display("FAIL t2_ch1_dout rep%0d got %h want %h", rep, socket_dout, exp_w); end
      s_tx_valid = 4'b1000;
      #1;
      n_cmp++; if (s_tx_ready !== 4'b1000) begin n_bad++; $display("FAIL t2_second_ready rep%0d got %b want 1000", rep, s_tx_ready); end
      tick();
      exp_w = {1'b1, 2'd3, 32'(32'h300 + rep)};
      n_cmp++; if (socket_dout_valid !== 1'b1 || socket_dout !== exp_w) begin n_bad++; $display("FAIL t2_ch3_dout rep%0d got %h want %h", rep, socket_dout, exp_w); end
      s_tx_valid = '0;
    end
  endtask

  task automatic test_burst_lock();
    logic [LW-1:0] exp_w;
    logic v2;
    int beat;
    beat = 0;
    s_tx_data = '0;
    s_tx_last = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      v2 = (cyc != 2);
      s_tx_valid = {1'b0, v2, 1'b0, (cyc > 0)};
      s_tx_data[2*DW +: DW] = 32'(32'h200 + beat);
      s_tx_data[0 +: DW] = 32'hD0;
      s_tx_last = {1'b0, (beat == 3), 2'b00};
      #1;
      n_cmp++; if (s_tx_ready !== 4'b0100) begin n_bad++; $display("FAIL t3_lock_ready cyc%0d got %b want 0100", cyc, s_tx_ready); end
      tick();
      if (v2) begin
        exp_w = {(beat == 3), 2'd2, 32'(32'h200 + beat)};
        n_cmp++; if (socket_dout_valid !== 1'b1 || socket_dout !== exp_w) begin n_bad++; $display("FAIL t3_dout cyc%0d got %b/%h want 1/%h", cyc, socket_dout_valid, socket_dout, exp_w); end
        beat++;
      end else begin
        n_cmp++; if (socket_dout_valid !== 1'b0) begin n_bad++; $display("FAIL t3_bubble cyc%0d got %b want 0", cyc, socket_dout_valid); end
      end
    end
    s_tx_valid = 4'b0001;
    s_tx_last = 4'b0001;
    #1;
    n_cmp++; if (s_tx_ready !== 4'b0001) begin n_bad++; $display("FAIL t3_after_ready got %b want 0001", s_tx_ready); end
    tick();
    exp_w = {1'b1, 2'd0, 32'hD0};
    n_cmp++; if (socket_dout !== exp_w) begin n_bad++; $display("FAIL t3_ch0_dout got %h want %h", socket_dout, exp_w); end
    s_tx_valid = '0;
    s_tx_last = '0;
  endtask

  task automatic test_rx_hol();
    logic [LW-1:0] w [5];
    logic [LW-1:0] ew;
    w[0] = {1'b1, 2'd2, 32'h55};
    w[1] = {1'b0, 2'd1, 32'h66};
    w[2] = {1'b0, 2'd1, 32'h77};
    w[3] = {1'b1, 2'd0, 32'h88};
    w[4] = {1'b0, 2'd3, 32'h99};
    do_reset();
    m_rx_ready = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (socket_din_ready !== (i <= 2)) begin n_bad++; $display("FAIL t4_din_ready count%0d got %b want %b", i, socket_din_ready, (i <= 2)); end
      if (i == 4) begin
        n_cmp++; if (err_rx_ovf !== 1'b0) begin n_bad++; $display("FAIL t4_ovf_early got %b want 0", err_rx_ovf); end
      end
      socket_din = w[i];
      socket_din_valid = 1'b1;
      tick();
    end
    socket_din_valid = 1'b0;
    n_cmp++; if (err_rx_ovf !== 1'b1) begin n_bad++; $display("FAIL t4_ovf_set got %b want 1", err_rx_ovf); end
    n_cmp++; if (m_rx_valid !== 4'b0100 || m_rx_data !== 32'h55) begin n_bad++; $display("FAIL t4_hol_head got %b/%h want 0100/55", m_rx_valid, m_rx_data); end
    m_rx_ready = 4'b1111;
    for (int j = 0; j < 4; j++) begin
      #1;
      ew = w[j];
      n_cmp++; if (m_rx_valid !== (4'b0001 << ew[33:32]) || m_rx_data !== ew[31:0] || m_rx_last !== ew[34]) begin n_bad++; $display("FAIL t4_drain%0d got %b/%h/%b want ch%0d/%h/%b", j, m_rx_valid, m_rx_data, m_rx_last, ew[33:32], ew[31:0], ew[34]); end
      tick();
    end
    n_cmp++; if (m_rx_valid !== 4'b0000 || err_rx_ovf !== 1'b1) begin n_bad++; $display("FAIL t4_end got v=%b ovf=%b want 0000/1", m_rx_valid, err_rx_ovf); end
    m_rx_ready = '0;
  endtask

  task automatic test_bad_ch();
    n_cmp++; if (err_bad3 !== 1'b0) begin n_bad++; $display("FAIL t5_pre_err got %b want 0", err_bad3); end
    m_rx_ready3 = 3'b111;
    din3 = {1'b0, 2'd3, 32'h99};
    din3_valid = 1'b1;
    tick();
    din3 = {1'b1, 2'd2, 32'hAB};
    #1;
    n_cmp++; if (err_bad3 !== 1'b1 || m_rx_valid3 !== 3'b000) begin n_bad++; $display("FAIL t5_bad_pulse got err=%b v=%b want 1/000", err_bad3, m_rx_valid3); end
    tick();
    din3_valid = 1'b0;
    #1;
    n_cmp++; if (err_bad3 !== 1'b0 || m_rx_valid3 !== 3'b100 || m_rx_data3 !== 32'hAB || m_rx_last3 !== 1'b1) begin n_bad++; $display("FAIL t5_next_route got err=%b v=%b d=%h l=%b want 0/100/ab/1", err_bad3, m_rx_valid3, m_rx_data3, m_rx_last3); end
    tick();
    n_cmp++; if (m_rx_valid3 !== 3'b000 || ovf3 !== 1'b0) begin n_bad++; $display("FAIL t5_drained got v=%b ovf=%b want 000/0", m_rx_valid3, ovf3); end
  endtask

  task automatic test_reset_mid();
    logic [LW-1:0] exp_w;
    n_cmp++; if (err_rx_ovf !== 1'b1) begin n_bad++; $display("FAIL t6_ovf_sticky got %b want 1", err_rx_ovf); end
    m_rx_ready = '0;
    for (int i = 0; i < 2; i++) begin
      s_tx_valid = 4'b0001;
      s_tx_last = '0;
      s_tx_data = '0;
      s_tx_data[DW-1:0] = 32'(32'hE0 + i);
      socket_din = {1'b0, 2'd1, 32'(32'h70 + i)};
      socket_din_valid = 1'b1;
      tick();
    end
    socket_din_valid = 1'b0;
    n_cmp++; if (m_rx_valid !== 4'b0010) begin n_bad++; $display("FAIL t6_fifo_loaded got %b want 0010", m_rx_valid); end
    rst = 1'b1;
    tick();
    n_cmp++; if (socket_dout_valid !== 1'b0 || socket_dout !== '0 || s_tx_ready !== 4'b0000) begin n_bad++; $display("FAIL t6_tx_cleared got %b/%h/%b want 0", socket_dout_valid, socket_dout, s_tx_ready); end
    n_cmp++; if (m_rx_valid !== 4'b0000 || m_rx_data !== '0 || m_rx_last !== 1'b0 || socket_din_ready !== 1'b0) begin n_bad++; $display("FAIL t6_rx_cleared got %b/%h/%b/%b want 0", m_rx_valid, m_rx_data, m_rx_last, socket_din_ready); end
    n_cmp++; if (err_rx_ovf !== 1'b0 || err_bad_ch !== 1'b0 || err_bad3 !== 1'b0 || ovf3 !== 1'b0) begin n_bad++; $display("FAIL t6_err_cleared got %b%b%b%b want 0000", err_rx_ovf, err_bad_ch, err_bad3, ovf3); end
    rst = 1'b0;
    s_tx_valid = 4'b0010;
    s_tx_last = 4'b0010;
    s_tx_data[1*DW +: DW] = 32'hF1;
    #1;
    n_cmp++; if (s_tx_ready !== 4'b0010 || socket_din_ready !== 1'b1) begin n_bad++; $display("FAIL t6_idle_after got %b/%b want 0010/1", s_tx_ready, socket_din_ready); end
    tick();
    exp_w = {1'b1, 2'd1, 32'hF1};
    n_cmp++; if (socket_dout_valid !== 1'b1 || socket_dout !== exp_w) begin n_bad++; $display("FAIL t6_dout got %b/%h want 1/%h", socket_dout_valid, socket_dout, exp_w); end
    s_tx_valid = '0;
    s_tx_last = '0;
  endtask

  task automatic test_random();
    int gen_left [N];
    logic [DW-1:0] gen_data [N];
    logic [LW-1:0] rxq [$];
    logic [LW-1:0] hw, rw, exp_dout;
    logic [N-1:0] v, exp_rdy;
    logic exp_v, exp_din_rdy, found;
    int m_rr, m_gnt, acc, c;
    logic m_burst;
    do_reset();
    m_rr = 0; m_gnt = 0; m_burst = 1'b0; exp_v = 1'b0; exp_dout = '0;
    for (int k = 0; k < N; k++) begin
      gen_left[k] = $urandom_range(1, 4);
      gen_data[k] = $urandom;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++; if (socket_dout_valid !== exp_v) begin n_bad++; $display("FAIL rnd_dout_valid cyc%0d got %b want %b", cyc, socket_dout_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (socket_dout !== exp_dout) begin n_bad++; $display("FAIL rnd_dout cyc%0d got %h want %h", cyc, socket_dout, exp_dout); end
      end
      for (int k = 0; k < N; k++) begin
        v[k] = ($urandom_range(0, 3) != 0);
        s_tx_data[k*DW +: DW] = gen_data[k];
        s_tx_last[k] = (gen_left[k] == 1);
      end
      s_tx_valid = v;
      acc = -1;
      exp_rdy = '0;
      if (m_burst) begin
        exp_rdy[m_gnt] = 1'b1;
        if (v[m_gnt]) acc = m_gnt;
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (m_rr + k) % N;
          if (!found && v[c]) begin
            found = 1'b1;
            acc = c;
            exp_rdy[c] = 1'b1;
          end
        end
      end
      exp_din_rdy = (rxq.size() <= DEP - 2);
      rw = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 32'($urandom)};
      socket_din = rw;
      socket_din_valid = exp_din_rdy && ($urandom_range(0, 1) == 1);
      m_rx_ready = 4'($urandom_range(0, 15));
      #1;
      n_cmp++; if (s_tx_ready !== exp_rdy) begin n_bad++; $display("FAIL rnd_tx_ready cyc%0d got %b want %b", cyc, s_tx_ready, exp_rdy); end
      n_cmp++; if (socket_din_ready !== exp_din_rdy) begin n_bad++; $display("FAIL rnd_din_ready cyc%0d got %b want %b", cyc, socket_din_ready, exp_din_rdy); end
      if (rxq.size() == 0) begin
        n_cmp++; if (m_rx_valid !== 4'b0000) begin n_bad++; $display("FAIL rnd_rx_empty cyc%0d got %b want 0000", cyc, m_rx_valid); end
      end else begin
        hw = rxq[0];
        n_cmp++; if (m_rx_valid !== (4'b0001 << hw[33:32]) || m_rx_data !== hw[31:0] || m_rx_last !== hw[34]) begin n_bad++; $display("FAIL rnd_rx_head cyc%0d got %b/%h/%b want ch%0d/%h/%b", cyc, m_rx_valid, m_rx_data, m_rx_last, hw[33:32], hw[31:0], hw[34]); end
        if (m_rx_ready[hw[33:32]]) void'(rxq.pop_front());
      end
      if (socket_din_valid) rxq.push_back(rw);
      if (acc >= 0) begin
        exp_v = 1'b1;
        exp_dout = {(gen_left[acc] == 1), 2'(acc), gen_data[acc]};
        if (gen_left[acc] == 1) begin
          m_burst = 1'b0;
          m_rr = (acc + 1) % N;
          gen_left[acc] = $urandom_range(1, 4);
        end else begin
          m_burst = 1'b1;
          m_gnt = acc;
          gen_left[acc] = gen_left[acc] - 1;
        end
        gen_data[acc] = $urandom;
      end else begin
        exp_v = 1'b0;
      end
      tick();
    end
    s_tx_valid = '0;
    socket_din_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_burst3();
    test_round_robin();
    test_burst_lock();
    test_rx_hol();
    test_bad_ch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
